calc_operand_stack: RTL and testbench
=====================================

# calc_operand_stack

Parametrised operand store for the hex calculator datapath. It sits between the keypad decoder and the arithmetic block. It assembles typed hex digits into the X (entry/display) operand, holds earlier operands on a DEPTH-deep LIFO whose top is Y, latches the pending operator, and commits the arithmetic result back into X on equals. It adds backspace, clear-entry/all-clear, digit-count limiting and overflow/underflow flags.

## Interface
- DIGITS, 4: hex digits per operand; W = 4*DIGITS.
- DEPTH, 4: operand stack entries below X (≥1).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- newhex  in  1  single-cycle pulse, hex key pressed.
- hexcode  in  4  digit value, valid with newhex.
- newop  in  1  single-cycle pulse, operator key pressed.
- opcode  in  2  operator, valid with newop.
- eq  in  1  single-cycle pulse, equals pressed.
- bksp  in  1  single-cycle pulse, delete last digit.
- clr  in  1  single-cycle pulse, clear-entry / all-clear.
- ans  in  W  combinational result from the arithmetic block (f(Y, X, op_reg)).
- x_reg  out  W  current entry/result, to display and arithmetic.
- y_reg  out  W  stack top; 0 when stack empty.
- op_reg  out  2  pending operator.
- digit_cnt  out  clog2(DIGITS+1)  digits typed in current entry.
- entry_full  out  1  digit_cnt == DIGITS.
- stack_cnt  out  clog2(DEPTH+1)  occupied stack entries.
- stack_ovf  out  1  sticky: a push discarded the bottom entry.
- stack_unf  out  1  sticky: eq with empty stack.

## Operation
- States: IDLE (X shows 0 or a cleared entry), ENTRY (digits being typed), RESULT (X holds a pushed or committed value; the next digit overwrites).
- One event per cycle. Priority: clr > eq > newop > bksp > newhex. Lower-priority pulses in the same cycle are dropped.
- newhex:
  - IDLE/RESULT: X←{0,hexcode}, digit_cnt←1, →ENTRY.
  - ENTRY with digit_cnt<DIGITS: X←{X[W-5:0],hexcode}, digit_cnt+1.
  - ENTRY with digit_cnt==DIGITS: ignored.
- bksp:
  - ENTRY: X←X>>4, digit_cnt−1; reaching 0 →IDLE.
  - IDLE/RESULT: ignored.
- newop: push X onto stack; op_reg←opcode; X unchanged; digit_cnt←0; →RESULT.
  - If stack_cnt==DEPTH, discard the bottom entry, set stack_ovf; stack_cnt stays DEPTH.
- eq:
  - stack_cnt>0: X←ans, pop (Y←next entry, 0 if it empties), digit_cnt←0, →RESULT.
  - stack_cnt==0: X unchanged, set stack_unf, →RESULT.
- clr:
  - ENTRY: X←0, digit_cnt←0, →IDLE; stack and op preserved (clear-entry).
  - IDLE/RESULT: all-clear; X, stack, op_reg, counts and both sticky flags ←0, →IDLE.
- Widths: no arithmetic inside the block. Shifts drop the high digit only when digit_cnt==DIGITS, which is prevented by the ignore rule.

## Timing
- Reset values: x_reg=0, y_reg=0, op_reg=0, digit_cnt=0, entry_full=0, stack_cnt=0, stack_ovf=0, stack_unf=0, state IDLE.
- All outputs are registered. An event at edge N is visible after edge N. Latency is 1 cycle.
- ans is sampled on the eq edge. It must be stable with respect to the pre-edge X, Y and op_reg.
- Back-to-back pulses on consecutive cycles are each processed, and each sees the prior cycle's update.
- Reset assertion mid-entry clears everything immediately, with no clock required. Release is synchronised externally.

## Structure
- Package calc_pkg holds:
  - state enum (IDLE, ENTRY, RESULT);
  - opcode constants ADD=0, SUB=1, MUL=2, AND=3;
  - event-priority encoding.
- Sub-module calc_lifo (params WIDTH, DEPTH):
  - ports: push, pop, clear, din, top, count, full, empty, push_drop;
  - push on full shifts out the bottom entry;
  - push and pop are never asserted together.
- Top-level FSM, entry register and digit counter in calc_operand_stack.

## Test plan
Bench parameters DIGITS=4, DEPTH=4.
- Reset, then type 1,2,3,4,5 → x_reg=0x1234, digit_cnt=4, entry_full=1; the fifth digit is ignored.
- Type A,B, bksp, C → x_reg=0x00AC; bksp×2 → x_reg=0, state IDLE.
- Type 7, newop(ADD), type 3, eq with ans=0x000A:
  - after newop: y_reg=7, x_reg=7, op_reg=0;
  - after eq: x_reg=0xA, stack_cnt=0.
- Five newop pushes of values 1..5 → stack_cnt=4, stack_ovf=1, y_reg=5; four eq pops empty the stack; a fifth eq → stack_unf=1, x_reg unchanged.
- newop and newhex in the same cycle → only the push occurs. clr in ENTRY with stack_cnt=2 → x_reg=0, stack_cnt=2. A second clr → all zero, flags clear.
- Assert reset asynchronously mid-entry (x_reg=0x0012) → outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the hex calculator operand store.
//   state_t   - entry FSM states
//   OP_*      - operator encodings carried on opcode/op_reg
//   event_t   - one-event-per-cycle encoding, with the priority decoder
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        RESULT
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_HEX,
        EV_BKSP,
        EV_OP,
        EV_EQ,
        EV_CLR
    } event_t;

    // clr > eq > newop > bksp > newhex; everything else that cycle is dropped
    function automatic event_t decode_event(input logic clr, input logic eq,
                                            input logic newop, input logic bksp,
                                            input logic newhex);
        if (clr)         return EV_CLR;
        else if (eq)     return EV_EQ;
        else if (newop)  return EV_OP;
        else if (bksp)   return EV_BKSP;
        else if (newhex) return EV_HEX;
        else             return EV_NONE;
    endfunction

endpackage

// File: rtl/calc_operand_stack_if.sv
// calc_operand_stack_if: keypad events, arithmetic result and operand outputs.
//   master - keypad/arithmetic side: drives events and ans, reads operands
//   slave  - operand store: reads events and ans, drives operands and flags
interface calc_operand_stack_if #(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 4
);
    localparam int W   = 4 * DIGITS;
    localparam int DCW = $clog2(DIGITS + 1);
    localparam int SCW = $clog2(DEPTH + 1);

    logic           newhex;
    logic [3:0]     hexcode;
    logic           newop;
    logic [1:0]     opcode;
    logic           eq;
    logic           bksp;
    logic           clr;
    logic [W-1:0]   ans;
    logic [W-1:0]   x_reg;
    logic [W-1:0]   y_reg;
    logic [1:0]     op_reg;
    logic [DCW-1:0] digit_cnt;
    logic           entry_full;
    logic [SCW-1:0] stack_cnt;
    logic           stack_ovf;
    logic           stack_unf;

    modport master (
        output newhex, hexcode, newop, opcode, eq, bksp, clr, ans,
        input  x_reg, y_reg, op_reg, digit_cnt, entry_full, stack_cnt,
               stack_ovf, stack_unf
    );

    modport slave (
        input  newhex, hexcode, newop, opcode, eq, bksp, clr, ans,
        output x_reg, y_reg, op_reg, digit_cnt, entry_full, stack_cnt,
               stack_ovf, stack_unf
    );
endinterface

// File: rtl/calc_lifo.sv
// calc_lifo: DEPTH-entry shift-register LIFO, mem[0] is the top.
//   push/pop/clear - single-cycle controls (push and pop never together)
//   din/top        - data in / current top (0 when empty)
//   count/full/empty, push_drop - occupancy; push_drop flags a push on full
module calc_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             push_drop
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_drop = push && full;
    // Vacated slots are zero-filled, so mem[0] already reads 0 when empty
    assign top       = mem[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else if (push) begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= din;
            if (!full) count <= count + 1'b1;
        end else if (pop && !empty) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/calc_operand_stack.sv
// calc_operand_stack: hex entry register X, operand LIFO (top = Y), pending
// operator and entry FSM for the hex calculator.
//   clock, reset - rising-edge clock, async active-low reset
//   bus (slave)  - keypad events and ans in; x/y/op, digit/stack counts,
//                  entry_full and sticky overflow/underflow flags out
module calc_operand_stack
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    calc_operand_stack_if.slave  bus
);
    localparam int W   = 4 * DIGITS;
    localparam int DCW = $clog2(DIGITS + 1);
    localparam int SCW = $clog2(DEPTH + 1);

    state_t         state;
    event_t         ev;
    logic [W-1:0]   x_q;
    logic [1:0]     op_q;
    logic [DCW-1:0] dcnt_q;
    logic           ovf_q;
    logic           unf_q;
    logic           entry_full;

    logic           push, pop, clear;
    logic [W-1:0]   top;
    logic [SCW-1:0] count;
    logic           full, empty, push_drop;

    assign ev         = decode_event(bus.clr, bus.eq, bus.newop, bus.bksp, bus.newhex);
    assign entry_full = (dcnt_q == DCW'(DIGITS));

    assign push  = (ev == EV_OP);
    assign pop   = (ev == EV_EQ) && !empty;
    assign clear = (ev == EV_CLR) && (state != ENTRY);

    calc_lifo #(.WIDTH(W), .DEPTH(DEPTH)) u_lifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .din       (x_q),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_drop (push_drop)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            x_q    <= '0;
            op_q   <= '0;
            dcnt_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            case (ev)
                EV_CLR: begin
                    x_q    <= '0;
                    dcnt_q <= '0;
                    state  <= IDLE;
                    // Outside ENTRY this is all-clear; the LIFO clears alongside
                    if (state != ENTRY) begin
                        op_q  <= '0;
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
                    end
                end
                EV_EQ: begin
                    dcnt_q <= '0;
                    state  <= RESULT;
                    if (!empty) x_q   <= bus.ans;
                    else        unf_q <= 1'b1;
                end
                EV_OP: begin
                    op_q   <= bus.opcode;
                    dcnt_q <= '0;
                    state  <= RESULT;
                    if (push_drop) ovf_q <= 1'b1;
                end
                EV_BKSP: begin
                    if (state == ENTRY) begin
                        x_q    <= x_q >> 4;
                        dcnt_q <= dcnt_q - 1'b1;
                        if (dcnt_q == DCW'(1)) state <= IDLE;
                    end
                end
                EV_HEX: begin
                    if (state != ENTRY) begin
                        x_q    <= W'(bus.hexcode);
                        dcnt_q <= DCW'(1);
                        state  <= ENTRY;
                    end else if (!entry_full) begin
                        x_q    <= {x_q[W-5:0], bus.hexcode};
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x_reg      = x_q;
    assign bus.y_reg      = top;
    assign bus.op_reg     = op_q;
    assign bus.digit_cnt  = dcnt_q;
    assign bus.entry_full = entry_full;
    assign bus.stack_cnt  = count;
    assign bus.stack_ovf  = ovf_q;
    assign bus.stack_unf  = unf_q;
endmodule

// File: tb/tb_calc_operand_stack.sv
// tb_calc_operand_stack: table-driven check of calc_operand_stack
// (DIGITS=4, DEPTH=4) with a scoreboard queue and an async-reset sequence.
module tb_calc_operand_stack;
    import calc_pkg::*;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_HEX  = 5'b00001;
    localparam logic [4:0] P_BKSP = 5'b00010;
    localparam logic [4:0] P_OP   = 5'b00100;
    localparam logic [4:0] P_EQ   = 5'b01000;
    localparam logic [4:0] P_CLR  = 5'b10000;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  op;
        logic [2:0]  dc;
        logic        full;
        logic [2:0]  sc;
        logic        ovf;
        logic        unf;
    } out_t;

    typedef struct packed {
        logic [4:0]  ev;
        logic [3:0]  hc;
        logic [1:0]  oc;
        logic [15:0] ans;
        out_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    vec_t tbl[$];

    calc_operand_stack_if #(.DIGITS(4), .DEPTH(4)) bus ();

    calc_operand_stack #(.DIGITS(4), .DEPTH(4)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [4:0] ev, input logic [3:0] hc,
                                input logic [1:0] oc, input logic [15:0] ans,
                                input logic [15:0] x, input logic [15:0] y,
                                input logic [1:0] op, input int dc, input int sc,
                                input logic ovf, input logic unf);
        vec_t v;
        v.ev  = ev;
        v.hc  = hc;
        v.oc  = oc;
        v.ans = ans;
        v.exp = '{x: x, y: y, op: op, dc: 3'(dc), full: (dc == 4), sc: 3'(sc),
                  ovf: ovf, unf: unf};
        return v;
    endfunction

    function automatic out_t sample();
        out_t a;
        a = '{x: bus.x_reg, y: bus.y_reg, op: bus.op_reg, dc: bus.digit_cnt,
              full: bus.entry_full, sc: bus.stack_cnt, ovf: bus.stack_ovf,
              unf: bus.stack_unf};
        return a;
    endfunction

    task automatic compare(input string name, input out_t req);
        out_t act;
        act = sample();
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act x=%h y=%h op=%0d dc=%0d full=%b sc=%0d ovf=%b unf=%b req x=%h y=%h op=%0d dc=%0d full=%b sc=%0d ovf=%b unf=%b",
                     name, act.x, act.y, act.op, act.dc, act.full, act.sc, act.ovf, act.unf,
                     req.x, req.y, req.op, req.dc, req.full, req.sc, req.ovf, req.unf);
        end
    endtask

    // Drive one cycle of pulses, queue the expectation, compare after the edge
    task automatic step(input string name, input vec_t v);
        out_t req;
        @(negedge clk);
        bus.clr     = v.ev[4];
        bus.eq      = v.ev[3];
        bus.newop   = v.ev[2];
        bus.bksp    = v.ev[1];
        bus.newhex  = v.ev[0];
        bus.hexcode = v.hc;
        bus.opcode  = v.oc;
        bus.ans     = v.ans;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        bus.clr = 1'b0; bus.eq = 1'b0; bus.newop = 1'b0;
        bus.bksp = 1'b0; bus.newhex = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            req = sb.pop_front();
            compare(name, req);
        end
    endtask

    initial begin
        out_t zero;
        zero = '0;
        rst_n = 1'b0;
        bus.clr = 1'b0; bus.eq = 1'b0; bus.newop = 1'b0; bus.bksp = 1'b0;
        bus.newhex = 1'b0; bus.hexcode = '0; bus.opcode = '0; bus.ans = '0;

        //                ev      hc    oc      ans      x        y        op      dc sc ovf unf
        tbl.push_back(mk(P_NONE, 4'h0, OP_ADD, 16'h0,    16'h0,   16'h0,   OP_ADD, 0, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h1, OP_ADD, 16'h0,    16'h1,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h2, OP_ADD, 16'h0,    16'h12,  16'h0,   OP_ADD, 2, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h3, OP_ADD, 16'h0,    16'h123, 16'h0,   OP_ADD, 3, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h4, OP_ADD, 16'h0,    16'h1234,16'h0,   OP_ADD, 4, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h5, OP_ADD, 16'h0,    16'h1234,16'h0,   OP_ADD, 4, 0, 0, 0));
        tbl.push_back(mk(P_CLR,  4'h0, OP_ADD, 16'h0,    16'h0,   16'h0,   OP_ADD, 0, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'hA, OP_ADD, 16'h0,    16'hA,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'hB, OP_ADD, 16'h0,    16'hAB,  16'h0,   OP_ADD, 2, 0, 0, 0));
        tbl.push_back(mk(P_BKSP, 4'h0, OP_ADD, 16'h0,    16'hA,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'hC, OP_ADD, 16'h0,    16'hAC,  16'h0,   OP_ADD, 2, 0, 0, 0));
        tbl.push_back(mk(P_BKSP, 4'h0, OP_ADD, 16'h0,    16'hA,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_BKSP, 4'h0, OP_ADD, 16'h0,    16'h0,   16'h0,   OP_ADD, 0, 0, 0, 0));
        tbl.push_back(mk(P_BKSP, 4'h0, OP_ADD, 16'h0,    16'h0,   16'h0,   OP_ADD, 0, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h7, OP_ADD, 16'h0,    16'h7,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_OP,   4'h0, OP_ADD, 16'h0,    16'h7,   16'h7,   OP_ADD, 0, 1, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h3, OP_ADD, 16'h0,    16'h3,   16'h7,   OP_ADD, 1, 1, 0, 0));
        tbl.push_back(mk(P_EQ,   4'h0, OP_ADD, 16'h000A, 16'hA,   16'h0,   OP_ADD, 0, 0, 0, 0));
        tbl.push_back(mk(P_CLR,  4'h0, OP_ADD, 16'h0,    16'h0,   16'h0,   OP_ADD, 0, 0, 0, 0));
        // Five pushes into a 4-deep stack: value 1 falls off the bottom
        tbl.push_back(mk(P_HEX,  4'h1, OP_ADD, 16'h0,    16'h1,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_OP,   4'h0, OP_SUB, 16'h0,    16'h1,   16'h1,   OP_SUB, 0, 1, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h2, OP_ADD, 16'h0,    16'h2,   16'h1,   OP_SUB, 1, 1, 0, 0));
        tbl.push_back(mk(P_OP,   4'h0, OP_MUL, 16'h0,    16'h2,   16'h2,   OP_MUL, 0, 2, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h3, OP_ADD, 16'h0,    16'h3,   16'h2,   OP_MUL, 1, 2, 0, 0));
        tbl.push_back(mk(P_OP,   4'h0, OP_AND, 16'h0,    16'h3,   16'h3,   OP_AND, 0, 3, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h4, OP_ADD, 16'h0,    16'h4,   16'h3,   OP_AND, 1, 3, 0, 0));
        tbl.push_back(mk(P_OP,   4'h0, OP_ADD, 16'h0,    16'h4,   16'h4,   OP_ADD, 0, 4, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h5, OP_ADD, 16'h0,    16'h5,   16'h4,   OP_ADD, 1, 4, 0, 0));
        tbl.push_back(mk(P_OP,   4'h0, OP_SUB, 16'h0,    16'h5,   16'h5,   OP_SUB, 0, 4, 1, 0));
        tbl.push_back(mk(P_EQ,   4'h0, OP_ADD, 16'h1111, 16'h1111,16'h4,   OP_SUB, 0, 3, 1, 0));
        tbl.push_back(mk(P_EQ,   4'h0, OP_ADD, 16'h2222, 16'h2222,16'h3,   OP_SUB, 0, 2, 1, 0));
        tbl.push_back(mk(P_EQ,   4'h0, OP_ADD, 16'h3333, 16'h3333,16'h2,   OP_SUB, 0, 1, 1, 0));
        tbl.push_back(mk(P_EQ,   4'h0, OP_ADD, 16'h4444, 16'h4444,16'h0,   OP_SUB, 0, 0, 1, 0));
        tbl.push_back(mk(P_EQ,   4'h0, OP_ADD, 16'h5555, 16'h4444,16'h0,   OP_SUB, 0, 0, 1, 1));
        // newop beats newhex in the same cycle
        tbl.push_back(mk(P_OP|P_HEX, 4'h9, OP_MUL, 16'h0, 16'h4444,16'h4444,OP_MUL, 0, 1, 1, 1));
        tbl.push_back(mk(P_HEX,  4'h6, OP_ADD, 16'h0,    16'h6,   16'h4444,OP_MUL, 1, 1, 1, 1));
        tbl.push_back(mk(P_OP,   4'h0, OP_AND, 16'h0,    16'h6,   16'h6,   OP_AND, 0, 2, 1, 1));
        tbl.push_back(mk(P_HEX,  4'h8, OP_ADD, 16'h0,    16'h8,   16'h6,   OP_AND, 1, 2, 1, 1));
        tbl.push_back(mk(P_CLR,  4'h0, OP_ADD, 16'h0,    16'h0,   16'h6,   OP_AND, 0, 2, 1, 1));
        tbl.push_back(mk(P_CLR,  4'h0, OP_ADD, 16'h0,    16'h0,   16'h0,   OP_ADD, 0, 0, 0, 0));
        // eq beats bksp; empty stack leaves X and raises underflow
        tbl.push_back(mk(P_HEX,  4'h1, OP_ADD, 16'h0,    16'h1,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_EQ|P_BKSP, 4'h0, OP_ADD, 16'hBEEF, 16'h1, 16'h0, OP_ADD, 0, 0, 0, 1));
        // clr beats everything; from RESULT it is all-clear
        tbl.push_back(mk(P_CLR|P_EQ|P_OP|P_HEX, 4'h3, OP_MUL, 16'h77, 16'h0, 16'h0, OP_ADD, 0, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h1, OP_ADD, 16'h0,    16'h1,   16'h0,   OP_ADD, 1, 0, 0, 0));
        tbl.push_back(mk(P_HEX,  4'h2, OP_ADD, 16'h0,    16'h12,  16'h0,   OP_ADD, 2, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Async reset mid-entry (X=0x0012): outputs clear before any clock edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 compare("async_reset", zero);
        @(negedge clk);
        compare("reset_held", zero);
        rst_n = 1'b1;
        step("post_reset_idle", mk(P_NONE, 4'h0, OP_ADD, 16'h0, 16'h0, 16'h0, OP_ADD, 0, 0, 0, 0));
        step("post_reset_hex",  mk(P_HEX,  4'h5, OP_ADD, 16'h0, 16'h5, 16'h0, OP_ADD, 1, 0, 0, 0));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover act=%0d req=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
